// File: rtl/serializer_pkg.sv
// Shared types and constants for the serializer transmitter.
// Optional parity state is only reachable when SERIALIZER_PARITY_EN is defined.
package serializer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity
  } state_e;

  // Bit counter width; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam logic SoutRst      = 1'b0;
  localparam logic SoutValidRst = 1'b0;
  localparam logic FrameRst     = 1'b0;

endpackage

// File: rtl/serializer_if.sv
// Parallel-in handshake and serial-out bundle of the serializer transmitter.
interface serializer_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame;
  logic             busy;

  // Transmitter side.
  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output sout,
    output sout_valid,
    output frame,
    output busy
  );

  // Producer / serial consumer side.
  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  sout,
    input  sout_valid,
    input  frame,
    input  busy
  );

endinterface

// File: rtl/serializer_bitcnt.sv
// Loadable down-counter with clock enable; reports the count and a zero flag.
module serializer_bitcnt #(
  parameter int unsigned CntW = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic [CntW-1:0] count_o,
  output logic            zero_o
);

  logic [CntW-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      if (load_i) begin
        count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/serializer_tx.sv
// Parallel-in serial-out transmitter with valid/ready input and registered serial output.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module serializer_tx
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic         clk,
  input logic         reset,
  input logic         en,
  serializer_if.slave bus
);

  localparam int unsigned CntW = cnt_w(WIDTH);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic             sout_d, sout_q;
  logic             sout_valid_d, sout_valid_q;
  logic             frame_d, frame_q;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CntW-1:0]  bit_cnt;
  logic             last_bit, din_ready, xfer;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_d, parity_q;
`endif

  serializer_bitcnt #(
    .CntW (CntW)
  ) u_bitcnt (
    .clk_i      (clk),
    .rst_ni     (reset),
    .en_i       (en),
    .load_i     (cnt_load),
    .load_val_i (CntW'(WIDTH - 1)),
    .dec_i      (cnt_dec),
    .count_o    (bit_cnt),
    .zero_o     (cnt_zero)
  );

  // last_bit marks the final bit of the frame on sout; a new word may follow with no gap.
`ifdef SERIALIZER_PARITY_EN
  assign last_bit = (state_q == StParity);
`else
  assign last_bit = (state_q == StShift) && cnt_zero;
`endif

  assign din_ready = reset & en & ((state_q == StIdle) | last_bit);
  assign xfer      = din_ready & bus.din_valid;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    frame_d      = frame_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d     = parity_q;
`endif
    if (en) begin
      if (xfer) begin
        state_d      = StShift;
        sout_valid_d = 1'b1;
        frame_d      = 1'b1;
        cnt_load     = 1'b1;
`ifdef SERIALIZER_PARITY_EN
        parity_d     = ^bus.din;
`endif
        // First bit goes straight to sout; shreg keeps only the bits still to send.
        if (MSB_FIRST) begin
          sout_d  = bus.din[WIDTH-1];
          shreg_d = {bus.din[WIDTH-2:0], 1'b0};
        end else begin
          sout_d  = bus.din[0];
          shreg_d = {1'b0, bus.din[WIDTH-1:1]};
        end
      end else begin
        unique case (state_q)
          StShift: begin
            frame_d = 1'b0;
            if (bit_cnt != '0) begin
              cnt_dec = 1'b1;
              if (MSB_FIRST) begin
                sout_d  = shreg_q[WIDTH-1];
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
              end else begin
                sout_d  = shreg_q[0];
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
              end
            end else begin
`ifdef SERIALIZER_PARITY_EN
              state_d = StParity;
              sout_d  = parity_q;
`else
              state_d      = StIdle;
              sout_d       = SoutRst;
              sout_valid_d = SoutValidRst;
`endif
            end
          end
`ifdef SERIALIZER_PARITY_EN
          StParity: begin
            state_d      = StIdle;
            sout_d       = SoutRst;
            sout_valid_d = SoutValidRst;
            frame_d      = FrameRst;
          end
`endif
          default: begin
            state_d      = StIdle;
            sout_d       = SoutRst;
            sout_valid_d = SoutValidRst;
            frame_d      = FrameRst;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      sout_q       <= SoutRst;
      sout_valid_q <= SoutValidRst;
      frame_q      <= FrameRst;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      frame_q      <= frame_d;
    end
  end

`ifdef SERIALIZER_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign bus.din_ready  = din_ready;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.frame      = frame_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: doc/serializer_tx.md
# serializer_tx

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock cycle. It is the sending end of the single-bit registered data path built from the team's enable-gated D flip-flops. It sits between a parallel producer, such as a counter or register bank, and any single-wire consumer, such as a shift-register receiver or an LED/GPIO pin.

## Interface
- WIDTH, 8, data word width in bits (≥2)
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- en  in  1  clock enable; when low, all state holds and no handshake completes
- din  in  WIDTH  parallel word to transmit
- din_valid  in  1  producer has a word on din
- din_ready  out  1  transmitter can accept a word this cycle (combinational)
- sout  out  1  serial data bit (registered)
- sout_valid  out  1  sout carries a frame bit (registered)
- frame  out  1  high on the first bit of each frame (registered)
- busy  out  1  frame in progress (state ≠ IDLE)

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- Reset (reset=0): state=IDLE; sout=0, sout_valid=0, frame=0, busy=0; din_ready=0 while reset is asserted.
- Transfer: din_valid & din_ready at a rising edge. Only counted when en=1.
- din_ready = reset & en & (state==IDLE | last_bit), where last_bit = final bit of the current frame is on sout.
- IDLE + transfer: load the shift register with din and the bit counter with WIDTH-1, then go to SHIFT. sout takes the first bit, sout_valid=1, frame=1.
- SHIFT, en=1: shift one bit and decrement the counter; frame=0 after the first bit.
- At counter==0 with no macro:
  - If a new transfer occurs, reload (back-to-back, no gap, frame=1).
  - Otherwise go to IDLE with sout_valid=0 and sout=0.
- en=0 in any state: registers hold, including sout and sout_valid; din_ready=0.
- din changes while busy are ignored; the word is captured only at the transfer.
- din_valid without din_ready: no effect. The producer must hold din/din_valid.

## Timing
- Latency: transfer at edge N, so the first bit is visible after edge N. Bit k is visible after edge N+k, for k = 0..WIDTH-1 with en held high.
- Frame length: WIDTH enabled cycles, or WIDTH+1 with parity.
- Throughput: one word per WIDTH (or WIDTH+1) enabled cycles, with no idle gap when din_valid stays high.
- Reset asserted mid-frame: outputs go to reset values immediately and asynchronously. The partial frame is discarded and not resumed.
- Reset deassertion is synchronous to clk by the system. The first transfer is possible at the first edge with reset=1 and en=1.

## Configuration
- SERIALIZER_PARITY_EN defined:
  - After the last data bit, enter PARITY for one enabled cycle, with sout = even-parity bit (XOR of the captured word) and sout_valid=1.
  - last_bit refers to the parity cycle.
- Not defined:
  - PARITY state and parity logic are absent.
  - The frame is WIDTH bits.

## Structure
- Package serializer_pkg:
  - state enum (IDLE, SHIFT, PARITY)
  - CNT_W = $clog2(WIDTH) helper
  - reset value constants for outputs
- Sub-module serializer_bitcnt:
  - loadable down-counter with en and asynchronous active-low reset
  - outputs count and zero flag
- Top: FSM, shift register and output registers.

## Test plan
- WIDTH=8, MSB_FIRST=1, din=0xA5, one transfer: sout=1,0,1,0,0,1,0,1 on 8 consecutive cycles, frame high on the first only, then sout_valid=0 and busy=0.
- din_valid held high with words 0xA5 then 0x3C: second frame starts on the cycle after the last bit of 0xA5, with no gap and frame=1; din_ready pulses high only on last bits.
- MSB_FIRST=0, din=0x01: sout=1 then seven 0s.
- en dropped for 3 cycles after bit 2 of 0xA5: sout/sout_valid frozen; stream resumes with bit 3; total frame = 8 enabled cycles.
- reset pulled low after bit 4: all outputs 0 immediately. After release, a new 0x3C frame transmits correctly from bit 0.
- SERIALIZER_PARITY_EN: 0xA5 appends parity 0; 0x07 appends parity 1; frame = 9 cycles; back-to-back reload occurs after the parity bit.
